// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: datapath width, opcode encodings and
// arbiter FSM state encoding.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Single-cycle 16-bit ALU; results wrap modulo 2^W, unused opcodes give 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   op_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SHL:  y_o = {a_i[W-2:0], 1'b0};
      OP_SHR:  y_o = {1'b0, a_i[W-1:1]};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid bit at or above ptr_i,
// searching upward with wrap-around.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  // Scan from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// Define ALU_ARB_ERR_EN to build the illegal-opcode flag register on rsp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int W       = ALU_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [W*NUM_REQ-1:0] req_a,
  input  logic [W*NUM_REQ-1:0] req_b,
  input  logic [4*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [W-1:0]         rsp_result,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      ptr_d;
  logic [IW-1:0]      gnt_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [3:0]         op_q;
  logic [W-1:0]       result_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  logic [W-1:0]       a_arr  [NUM_REQ];
  logic [W-1:0]       b_arr  [NUM_REQ];
  logic [3:0]         op_arr [NUM_REQ];

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [W-1:0]       alu_y;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[gi*W +: W];
      assign b_arr[gi]  = req_b[gi*W +: W];
      assign op_arr[gi] = req_op[gi*4 +: 4];
    end
  endgenerate

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  alu_core #(
    .W (W)
  ) u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  // ready is gated by rst so it stays low while reset is held in IDLE.
  assign req_ready  = (state_q == ST_IDLE && !rst) ? pick_grant : '0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign busy       = (state_q != ST_IDLE);
  assign ptr_d      = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_q   <= pick_idx;
            a_q     <= a_arr[pick_idx];
            b_q     <= b_arr[pick_idx];
            op_q    <= op_arr[pick_idx];
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q    <= alu_y;
          rsp_valid_q <= NUM_REQ'(1) << gnt_q;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= ptr_d;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      err_q <= (op_q >= 4'd7);
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
